memory_stage: RTL

Pipeline MEM stage of the MIPS core: latches the execute-stage results into the EX/MEM register, performs data-memory loads and stores with byte, halfword and word granularity, and presents registered results to write-back through the MEM/WB register. It also drives the EX/MEM forwarding value back to execute, and provides a word-wide debug read port for the debug unit.

---
 rtl/memory_stage_if.sv | 51 +++++
 rtl/memory_stage.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/memory_stage_if.sv
// rtl/memory_stage_if.sv - EX->MEM->WB pipeline bundle and debug read port for the MEM stage
interface memory_stage_if #(
  parameter int DATA_SIZE     = 32,
  parameter int REG_SIZE      = 5,
  parameter int PC_SIZE       = 32,
  parameter int MEM_ADDR_SIZE = 8
);
  logic                     i_enable;
  logic                     i_signed;
  logic                     i_reg_write;
  logic                     i_mem_to_reg;
  logic                     i_mem_read;
  logic                     i_mem_write;
  logic                     i_byte_enable;
  logic                     i_halfword_enable;
  logic                     i_word_enable;
  logic [DATA_SIZE-1:0]     i_alu_result;
  logic [DATA_SIZE-1:0]     i_data_b;
  logic [REG_SIZE-1:0]      i_selected_reg;
  logic                     i_last_register_ctrl;
  logic                     i_halt;
  logic [PC_SIZE-1:0]       i_pc;
  logic [MEM_ADDR_SIZE-1:0] i_debug_addr;

  logic [DATA_SIZE-1:0]     o_mem_fwd_data;
  logic                     o_reg_write;
  logic                     o_mem_to_reg;
  logic [DATA_SIZE-1:0]     o_read_data;
  logic [DATA_SIZE-1:0]     o_alu_result;
  logic [REG_SIZE-1:0]      o_selected_reg;
  logic                     o_last_register_ctrl;
  logic                     o_halt;
  logic [PC_SIZE-1:0]       o_pc;
  logic [DATA_SIZE-1:0]     o_debug_data;

  modport master (
    output i_enable, i_signed, i_reg_write, i_mem_to_reg, i_mem_read, i_mem_write,
           i_byte_enable, i_halfword_enable, i_word_enable, i_alu_result, i_data_b,
           i_selected_reg, i_last_register_ctrl, i_halt, i_pc, i_debug_addr,
    input  o_mem_fwd_data, o_reg_write, o_mem_to_reg, o_read_data, o_alu_result,
           o_selected_reg, o_last_register_ctrl, o_halt, o_pc, o_debug_data
  );

  modport slave (
    input  i_enable, i_signed, i_reg_write, i_mem_to_reg, i_mem_read, i_mem_write,
           i_byte_enable, i_halfword_enable, i_word_enable, i_alu_result, i_data_b,
           i_selected_reg, i_last_register_ctrl, i_halt, i_pc, i_debug_addr,
    output o_mem_fwd_data, o_reg_write, o_mem_to_reg, o_read_data, o_alu_result,
           o_selected_reg, o_last_register_ctrl, o_halt, o_pc, o_debug_data
  );
endinterface

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MIPS MEM stage: EX/MEM latch, byte/half/word data memory, MEM/WB latch
module memory_stage #(
  parameter int DATA_SIZE     = 32,
  parameter int REG_SIZE      = 5,
  parameter int PC_SIZE       = 32,
  parameter int MEM_ADDR_SIZE = 8
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  memory_stage_if.slave bus
);
  localparam int DEPTH = 1 << MEM_ADDR_SIZE;

  logic                 ex_signed;
  logic                 ex_reg_write;
  logic                 ex_mem_to_reg;
  logic                 ex_mem_read;
  logic                 ex_mem_write;
  logic                 ex_byte_en;
  logic                 ex_half_en;
  logic                 ex_word_en;
  logic [DATA_SIZE-1:0] ex_alu_result;
  logic [DATA_SIZE-1:0] ex_data_b;
  logic [REG_SIZE-1:0]  ex_selected_reg;
  logic                 ex_last_register_ctrl;
  logic                 ex_halt;
  logic [PC_SIZE-1:0]   ex_pc;

  logic                 wb_reg_write;
  logic                 wb_mem_to_reg;
  logic [DATA_SIZE-1:0] wb_read_data;
  logic [DATA_SIZE-1:0] wb_alu_result;
  logic [REG_SIZE-1:0]  wb_selected_reg;
  logic                 wb_last_register_ctrl;
  logic                 wb_halt;
  logic [PC_SIZE-1:0]   wb_pc;

  logic [DATA_SIZE-1:0]     mem [DEPTH];
  logic [MEM_ADDR_SIZE-1:0] word_idx;
  logic [1:0]               lane;
  logic [DATA_SIZE-1:0]     cur_word;
  logic [DATA_SIZE-1:0]     store_word;
  logic                     store_en;
  logic [7:0]               sel_byte;
  logic [15:0]              sel_half;
  logic [DATA_SIZE-1:0]     load_data;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ex_signed             <= 1'b0;
      ex_reg_write          <= 1'b0;
      ex_mem_to_reg         <= 1'b0;
      ex_mem_read           <= 1'b0;
      ex_mem_write          <= 1'b0;
      ex_byte_en            <= 1'b0;
      ex_half_en            <= 1'b0;
      ex_word_en            <= 1'b0;
      ex_alu_result         <= '0;
      ex_data_b             <= '0;
      ex_selected_reg       <= '0;
      ex_last_register_ctrl <= 1'b0;
      ex_halt               <= 1'b0;
      ex_pc                 <= '0;
    end else if (bus.i_enable) begin
      ex_signed             <= bus.i_signed;
      ex_reg_write          <= bus.i_reg_write;
      ex_mem_to_reg         <= bus.i_mem_to_reg;
      ex_mem_read           <= bus.i_mem_read;
      ex_mem_write          <= bus.i_mem_write;
      ex_byte_en            <= bus.i_byte_enable;
      ex_half_en            <= bus.i_halfword_enable;
      ex_word_en            <= bus.i_word_enable;
      ex_alu_result         <= bus.i_alu_result;
      ex_data_b             <= bus.i_data_b;
      ex_selected_reg       <= bus.i_selected_reg;
      ex_last_register_ctrl <= bus.i_last_register_ctrl;
      ex_halt               <= bus.i_halt;
      ex_pc                 <= bus.i_pc;
    end
  end

  // Upper address bits are dropped, so accesses wrap around the 2^MEM_ADDR_SIZE-word array.
  assign word_idx = ex_alu_result[MEM_ADDR_SIZE+1:2];
  assign lane     = ex_alu_result[1:0];
  assign cur_word = mem[word_idx];

  // Store merge: word beats halfword beats byte; untouched lanes keep the old contents.
  always_comb begin
    store_word = cur_word;
    store_en   = 1'b0;
    if (ex_word_en) begin
      store_word = ex_data_b;
      store_en   = ex_mem_write;
    end else if (ex_half_en) begin
      store_word[{lane[1], 4'b0000} +: 16] = ex_data_b[15:0];
      store_en                             = ex_mem_write;
    end else if (ex_byte_en) begin
      store_word[{lane, 3'b000} +: 8] = ex_data_b[7:0];
      store_en                        = ex_mem_write;
    end
  end

  always_comb begin
    sel_byte  = cur_word[{lane, 3'b000} +: 8];
    sel_half  = cur_word[{lane[1], 4'b0000} +: 16];
    load_data = '0;
    if (ex_mem_read) begin
      if (ex_word_en) begin
        load_data = cur_word;
      end else if (ex_half_en) begin
        load_data = {{(DATA_SIZE-16){ex_signed & sel_half[15]}}, sel_half};
      end else if (ex_byte_en) begin
        load_data = {{(DATA_SIZE-8){ex_signed & sel_byte[7]}}, sel_byte};
      end
    end
  end

  // No reset on the array: contents survive reset, and a cleared EX/MEM drops any pending store.
  always_ff @(posedge i_clk) begin
    if (bus.i_enable && store_en) begin
      mem[word_idx] <= store_word;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wb_reg_write          <= 1'b0;
      wb_mem_to_reg         <= 1'b0;
      wb_read_data          <= '0;
      wb_alu_result         <= '0;
      wb_selected_reg       <= '0;
      wb_last_register_ctrl <= 1'b0;
      wb_halt               <= 1'b0;
      wb_pc                 <= '0;
    end else if (bus.i_enable) begin
      wb_reg_write          <= ex_reg_write;
      wb_mem_to_reg         <= ex_mem_to_reg;
      wb_read_data          <= load_data;
      wb_alu_result         <= ex_alu_result;
      wb_selected_reg       <= ex_selected_reg;
      wb_last_register_ctrl <= ex_last_register_ctrl;
      wb_halt               <= ex_halt;
      wb_pc                 <= ex_pc;
    end
  end

  assign bus.o_mem_fwd_data       = ex_alu_result;
  assign bus.o_reg_write          = wb_reg_write;
  assign bus.o_mem_to_reg         = wb_mem_to_reg;
  assign bus.o_read_data          = wb_read_data;
  assign bus.o_alu_result         = wb_alu_result;
  assign bus.o_selected_reg       = wb_selected_reg;
  assign bus.o_last_register_ctrl = wb_last_register_ctrl;
  assign bus.o_halt               = wb_halt;
  assign bus.o_pc                 = wb_pc;
  assign bus.o_debug_data         = mem[bus.i_debug_addr];
endmodule
